// File: rtl/in_dma_read_engine_pkg.sv
// -----------------------------------------------------------------------------
// in_dma_read_engine_pkg
// Shared definitions for the input-buffer DMA read engine:
//   - AXI4 encodings used by the read master (size, burst type, response).
//   - FSM state encoding for the engine controller.
//   - Beat geometry (a 256-bit beat is 32 bytes, so 5 address offset bits).
// -----------------------------------------------------------------------------
package in_dma_read_engine_pkg;

    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Number of low address bits covered by one 32-byte beat.
    localparam int BEAT_OFFSET_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/in_dma_read_engine_if.sv
// -----------------------------------------------------------------------------
// in_dma_read_engine_if
// Bundles the AXI4 read-address / read-data channels and the downstream beat
// stream of the DMA read engine.
//   master modport : the engine (drives AR, RREADY and the output stream).
//   slave  modport : the environment (AXI slave plus input-buffer controller).
// Parameters: DATA_W (beat width), ADDR_W (AXI address width).
// -----------------------------------------------------------------------------
interface in_dma_read_engine_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32
);
    // AXI read address channel
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    // AXI read data channel
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    // Downstream beat stream
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  out_valid, out_data,
        output out_ready
    );

endinterface

// File: rtl/in_dma_read_engine_beat_fifo.sv
// -----------------------------------------------------------------------------
// in_dma_read_engine_beat_fifo
// Synchronous beat FIFO with a registered head word.
//   clk, rst   : clock, asynchronous active-high reset.
//   push/push_data : write a word (accepted when not full, or when full and
//                    popping in the same cycle).
//   pop        : remove the head word (ignored when empty).
//   full/empty : registered occupancy flags.
//   head       : registered copy of the oldest word; valid while !empty.
// A word pushed into an empty FIFO appears on head the following cycle.
// -----------------------------------------------------------------------------
module in_dma_read_engine_beat_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push_ok;
    logic             pop_ok;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (pop_ok)
            rd_ptr_nxt = rd_ptr + 1'b1;
        if (push_ok && !pop_ok)
            count_nxt = count + 1'b1;
        else if (pop_ok && !push_ok)
            count_nxt = count - 1'b1;
    end

    // NOTE: the storage array carries no reset; only pointers, flags and the
    // head register need a defined value, and the array is never read before
    // it has been written.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            head   <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == CNT_W'(DEPTH));
            empty  <= (count_nxt == '0);
            // Refresh the head copy whenever the oldest entry may change. If
            // the incoming word lands exactly in the new head slot (FIFO was
            // empty, or drains to it this cycle) it bypasses the array.
            if ((push_ok || pop_ok) && count_nxt != '0) begin
                if (push_ok && wr_ptr == rd_ptr_nxt)
                    head <= push_data;
                else
                    head <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/in_dma_read_engine.sv
// -----------------------------------------------------------------------------
// in_dma_read_engine
// AXI4 read master for the accelerator input buffer. A one-cycle dma_start
// launches a single INCR burst of 256-bit beats; returned beats are queued in
// a small FIFO and replayed on a valid/ready stream, decoupling R-channel
// backpressure from input-buffer readiness.
//   clk, rst      : clock, asynchronous active-high reset.
//   dma_start     : request pulse, honoured only while dma_ready.
//   dma_addr      : burst start address (32-byte aligned; low bits forced 0).
//   dma_burst_len : beats minus one.
//   dma_ready     : engine idle.
//   dma_err       : sticky error (start while busy, misaligned address,
//                   non-OKAY response, rlast mismatch); cleared by rst only.
//   bus           : AXI AR/R channels and the output beat stream.
// -----------------------------------------------------------------------------
module in_dma_read_engine
    import in_dma_read_engine_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dma_start,
    input  logic [ADDR_W-1:0]    dma_addr,
    input  logic [3:0]           dma_burst_len,
    output logic                 dma_ready,
    output logic                 dma_err,
    in_dma_read_engine_if.master bus
);

    state_t            state;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic              arvalid_q;
    logic [3:0]        beat_cnt;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    logic r_beat;
    logic last_beat;
    logic start_err;
    logic addr_err;
    logic resp_err;
    logic last_err;

    assign r_beat    = bus.m_axi_rvalid && bus.m_axi_rready;
    assign last_beat = (beat_cnt == 4'd0);

    assign start_err = dma_start && (state != ST_IDLE);
    assign addr_err  = dma_start && (state == ST_IDLE) && (dma_addr[BEAT_OFFSET_W-1:0] != '0);
    assign resp_err  = r_beat && (bus.m_axi_rresp != AXI_RESP_OKAY);
    // The beat counter ends the burst; rlast is only cross-checked against it.
    assign last_err  = r_beat && (bus.m_axi_rlast != last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            dma_ready <= 1'b1;
            dma_err   <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (start_err || addr_err || resp_err || last_err)
                dma_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (dma_start) begin
                        araddr_q  <= {dma_addr[ADDR_W-1:BEAT_OFFSET_W], {BEAT_OFFSET_W{1'b0}}};
                        arlen_q   <= {4'b0, dma_burst_len};
                        beat_cnt  <= dma_burst_len;
                        arvalid_q <= 1'b1;
                        dma_ready <= 1'b0;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_beat) begin
                        if (last_beat) begin
                            dma_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    dma_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    in_dma_read_engine_beat_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_beat),
        .push_data (bus.m_axi_rdata),
        .pop       (bus.out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = AXI_SIZE_32B;
    assign bus.m_axi_arburst = AXI_BURST_INCR;
    assign bus.m_axi_arvalid = arvalid_q;
    // Uses the registered full flag: a full FIFO that is popping this cycle
    // still holds R off for that cycle.
    assign bus.m_axi_rready  = (state == ST_DATA) && !fifo_full;
    assign bus.out_valid     = !fifo_empty;
    assign bus.out_data      = fifo_head;

endmodule

// File: tb/tb_in_dma_read_engine.sv
// -----------------------------------------------------------------------------
// tb_in_dma_read_engine
// Directed bench for in_dma_read_engine: drives the AXI slave side and the
// downstream ready by hand, records stream beats with a monitor, and compares
// against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_in_dma_read_engine;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dma_start = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [3:0]        dma_burst_len = '0;
    logic              dma_ready;
    logic              dma_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int r_cnt    = 0;

    logic [DATA_W-1:0] got_q [$];
    logic [DATA_W-1:0] exp_q [$];

    in_dma_read_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    in_dma_read_engine #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dma_start     (dma_start),
        .dma_addr      (dma_addr),
        .dma_burst_len (dma_burst_len),
        .dma_ready     (dma_ready),
        .dma_err       (dma_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are stable from posedge+1 through the next posedge, so the
    // falling edge sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready)
                got_q.push_back(bus.out_data);
            if (bus.m_axi_rvalid && bus.m_axi_rready)
                r_cnt <= r_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dma_start = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rresp   = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start(input logic [ADDR_W-1:0] a, input logic [3:0] len);
        dma_start = 1'b1;
        dma_addr = a;
        dma_burst_len = len;
        tick();
        dma_start = 1'b0;
    endtask

    task automatic ar_accept(input int delay, output logic [ADDR_W-1:0] a, output logic [7:0] len);
        int n = 0;
        @(negedge clk);
        while (!bus.m_axi_arvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("arvalid_wait", DATA_W'(bus.m_axi_arvalid), DATA_W'(1));
        repeat (delay) @(negedge clk);
        a = bus.m_axi_araddr;
        len = bus.m_axi_arlen;
        bus.m_axi_arready = 1'b1;
        tick();
        bus.m_axi_arready = 1'b0;
    endtask

    task automatic r_beat(input logic [DATA_W-1:0] d, input logic [1:0] resp, input logic last);
        int n = 0;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = d;
        bus.m_axi_rresp  = resp;
        bus.m_axi_rlast  = last;
        @(negedge clk);
        while (!bus.m_axi_rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rready_wait", DATA_W'(bus.m_axi_rready), DATA_W'(1));
        tick();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_count"}, DATA_W'(got_q.size() - base), DATA_W'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check({tag, "_beat"}, got_q[base + i], exp_q[i]);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [7:0]        l;
        int                base;
        int                c0;
        int                r0;

        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rlast   = 1'b0;
        bus.out_ready     = 1'b1;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_dma_ready", DATA_W'(dma_ready), DATA_W'(1));
        check("rst_dma_err",   DATA_W'(dma_err), DATA_W'(0));
        check("rst_arvalid",   DATA_W'(bus.m_axi_arvalid), DATA_W'(0));
        check("rst_araddr",    DATA_W'(bus.m_axi_araddr), DATA_W'(0));
        check("rst_arlen",     DATA_W'(bus.m_axi_arlen), DATA_W'(0));
        check("rst_rready",    DATA_W'(bus.m_axi_rready), DATA_W'(0));
        check("rst_out_valid", DATA_W'(bus.out_valid), DATA_W'(0));
        check("rst_out_data",  bus.out_data, DATA_W'(0));
        check("arsize",        DATA_W'(bus.m_axi_arsize), DATA_W'(3'b101));
        check("arburst",       DATA_W'(bus.m_axi_arburst), DATA_W'(2'b01));
        rst = 1'b0;
        tick();

        // ---------------- single burst ----------------
        base = got_q.size();
        start(32'h1000, 4'd2);
        check("t1_arvalid_rise", DATA_W'(bus.m_axi_arvalid), DATA_W'(1));
        check("t1_busy",         DATA_W'(dma_ready), DATA_W'(0));
        ar_accept(3, a, l);
        check("t1_araddr", DATA_W'(a), DATA_W'(32'h1000));
        check("t1_arlen",  DATA_W'(l), DATA_W'(2));
        c0 = cyc;
        r_beat(256'hA0, 2'b00, 1'b0);
        check("t1_first_valid", DATA_W'(bus.out_valid), DATA_W'(1));
        check("t1_first_data",  bus.out_data, 256'hA0);
        r_beat(256'hA1, 2'b00, 1'b0);
        r_beat(256'hA2, 2'b00, 1'b1);
        check("t1_throughput", DATA_W'(cyc - c0), DATA_W'(3));
        check("t1_ready_back", DATA_W'(dma_ready), DATA_W'(1));
        repeat (3) tick();
        exp_q.delete();
        exp_q.push_back(256'hA0);
        exp_q.push_back(256'hA1);
        exp_q.push_back(256'hA2);
        check_stream("t1_stream", base);
        check("t1_err", DATA_W'(dma_err), DATA_W'(0));

        // ---------------- backpressure ----------------
        base = got_q.size();
        r0 = r_cnt;
        bus.out_ready = 1'b0;
        start(32'h3000, 4'd7);
        ar_accept(0, a, l);
        check("t2_arlen", DATA_W'(l), DATA_W'(7));
        for (int i = 0; i < 4; i++)
            r_beat(DATA_W'(8'hB0 + i), 2'b00, 1'b0);
        check("t2_rready_full", DATA_W'(bus.m_axi_rready), DATA_W'(0));
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 256'hB4;
        tick();
        tick();
        check("t2_rready_hold", DATA_W'(bus.m_axi_rready), DATA_W'(0));
        check("t2_r_accepted",  DATA_W'(r_cnt - r0), DATA_W'(4));
        check("t2_head_hold",   bus.out_data, 256'hB0);
        check("t2_valid_hold",  DATA_W'(bus.out_valid), DATA_W'(1));
        bus.out_ready = 1'b1;
        for (int i = 4; i < 8; i++)
            r_beat(DATA_W'(8'hB0 + i), 2'b00, i == 7);
        repeat (6) tick();
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            exp_q.push_back(DATA_W'(8'hB0 + i));
        check_stream("t2_stream", base);
        check("t2_ready", DATA_W'(dma_ready), DATA_W'(1));
        check("t2_err",   DATA_W'(dma_err), DATA_W'(0));

        // ---------------- back-to-back ----------------
        base = got_q.size();
        bus.out_ready = 1'b0;
        start(32'h4000, 4'd1);
        ar_accept(0, a, l);
        r_beat(256'hC0, 2'b00, 1'b0);
        r_beat(256'hC1, 2'b00, 1'b1);
        check("t3_idle_after_final", DATA_W'(dma_ready), DATA_W'(1));
        start(32'h2000, 4'd1);
        check("t3_second_accepted", DATA_W'(bus.m_axi_arvalid), DATA_W'(1));
        ar_accept(0, a, l);
        check("t3_araddr2", DATA_W'(a), DATA_W'(32'h2000));
        check("t3_arlen2",  DATA_W'(l), DATA_W'(1));
        r_beat(256'hD0, 2'b00, 1'b0);
        r_beat(256'hD1, 2'b00, 1'b1);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        exp_q.delete();
        exp_q.push_back(256'hC0);
        exp_q.push_back(256'hC1);
        exp_q.push_back(256'hD0);
        exp_q.push_back(256'hD1);
        check_stream("t3_stream", base);
        check("t3_err", DATA_W'(dma_err), DATA_W'(0));

        // ---------------- start while busy ----------------
        base = got_q.size();
        start(32'h5000, 4'd0);
        dma_start = 1'b1;
        dma_addr = 32'h6000;
        dma_burst_len = 4'd3;
        tick();
        dma_start = 1'b0;
        check("t4_busy_err", DATA_W'(dma_err), DATA_W'(1));
        ar_accept(0, a, l);
        check("t4_araddr_kept", DATA_W'(a), DATA_W'(32'h5000));
        check("t4_arlen_kept",  DATA_W'(l), DATA_W'(0));
        r_beat(256'hE0, 2'b00, 1'b1);
        repeat (3) tick();
        check("t4_ready", DATA_W'(dma_ready), DATA_W'(1));
        exp_q.delete();
        exp_q.push_back(256'hE0);
        check_stream("t4_stream", base);

        // ---------------- error response ----------------
        do_reset();
        check("t5_err_cleared", DATA_W'(dma_err), DATA_W'(0));
        base = got_q.size();
        start(32'h7000, 4'd0);
        ar_accept(0, a, l);
        r_beat(256'hF0, 2'b10, 1'b1);
        check("t5_resp_err", DATA_W'(dma_err), DATA_W'(1));
        repeat (3) tick();
        exp_q.delete();
        exp_q.push_back(256'hF0);
        check_stream("t5_stream", base);

        // ---------------- early rlast ----------------
        do_reset();
        base = got_q.size();
        r0 = r_cnt;
        start(32'h8000, 4'd1);
        ar_accept(0, a, l);
        r_beat(256'h60, 2'b00, 1'b1);
        check("t6_rlast_err",  DATA_W'(dma_err), DATA_W'(1));
        check("t6_still_busy", DATA_W'(dma_ready), DATA_W'(0));
        r_beat(256'h61, 2'b00, 1'b1);
        check("t6_done", DATA_W'(dma_ready), DATA_W'(1));
        repeat (3) tick();
        check("t6_r_count", DATA_W'(r_cnt - r0), DATA_W'(2));
        exp_q.delete();
        exp_q.push_back(256'h60);
        exp_q.push_back(256'h61);
        check_stream("t6_stream", base);

        // ---------------- misaligned address ----------------
        do_reset();
        start(32'h1014, 4'd0);
        check("t7_misalign_err", DATA_W'(dma_err), DATA_W'(1));
        ar_accept(0, a, l);
        check("t7_araddr_aligned", DATA_W'(a), DATA_W'(32'h1000));
        r_beat(256'h70, 2'b00, 1'b1);
        repeat (2) tick();

        // ---------------- reset while arvalid ----------------
        do_reset();
        start(32'hA000, 4'd0);
        check("t8_arvalid_up", DATA_W'(bus.m_axi_arvalid), DATA_W'(1));
        rst = 1'b1;
        #1;
        check("t8_arvalid_async", DATA_W'(bus.m_axi_arvalid), DATA_W'(0));
        tick();
        rst = 1'b0;
        tick();

        // ---------------- reset mid-burst ----------------
        bus.out_ready = 1'b0;
        start(32'h9000, 4'd3);
        ar_accept(0, a, l);
        r_beat(256'h90, 2'b00, 1'b0);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 256'h91;
        check("t9_rready_up", DATA_W'(bus.m_axi_rready), DATA_W'(1));
        check("t9_valid_up",  DATA_W'(bus.out_valid), DATA_W'(1));
        rst = 1'b1;
        #1;
        check("t9_rready_async", DATA_W'(bus.m_axi_rready), DATA_W'(0));
        check("t9_valid_async",  DATA_W'(bus.out_valid), DATA_W'(0));
        check("t9_arvalid_low",  DATA_W'(bus.m_axi_arvalid), DATA_W'(0));
        bus.m_axi_rvalid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("t9_ready_after", DATA_W'(dma_ready), DATA_W'(1));
        check("t9_fifo_empty",  DATA_W'(bus.out_valid), DATA_W'(0));
        check("t9_err_clear",   DATA_W'(dma_err), DATA_W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
